// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type execution controller.
// Holds the R-type opcode, the supported funct codes and the controller
// state encoding used by rtype_exec_ctrl and rtype_alu.
package rtype_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'h00;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

endpackage

// File: rtl/rtype_alu.sv
// Combinational ALU for MIPS R-type instructions.
// Ports:
//   opA, opB     - operands (rs, rt values); shifts operate on opB
//   shamt        - shift amount field
//   funct        - function field
//   res          - result, modulo 2^DATA_W; 0 for unsupported funct
//   legal_funct  - 1 when funct is a supported operation
module rtype_alu
    import rtype_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    output logic [DATA_W-1:0] res,
    output logic              legal_funct
);

    always_comb begin
        res         = '0;
        legal_funct = 1'b1;
        case (funct)
            FUNCT_ADD, FUNCT_ADDU: res = opA + opB;
            FUNCT_SUB, FUNCT_SUBU: res = opA - opB;
            FUNCT_AND:             res = opA & opB;
            FUNCT_OR:              res = opA | opB;
            FUNCT_XOR:             res = opA ^ opB;
            FUNCT_NOR:             res = ~(opA | opB);
            FUNCT_SLT:             res = {{(DATA_W-1){1'b0}}, ($signed(opA) < $signed(opB))};
            FUNCT_SLTU:            res = {{(DATA_W-1){1'b0}}, (opA < opB)};
            FUNCT_SLL:             res = opB << shamt;
            FUNCT_SRL:             res = opB >> shamt;
            FUNCT_SRA:             res = DATA_W'($signed(opB) >>> shamt);
            default: begin
                res         = '0;
                legal_funct = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rtype_exec_ctrl.sv
// Non-pipelined R-type execution controller in front of a 32x32 register
// file. Accepts one instruction per handshake, reads rs/rt, executes the
// ALU function and writes rd back.  IDLE -> READ -> EXEC -> WB -> IDLE.
// Ports:
//   clk, reset           - clock, async active-low reset
//   instr_valid/ready    - instruction handshake; instr is the R-type word
//   srcRegA/B, outBusA/B - register file read address / data
//   regWrite, destReg, writeData - register file write port
//   done, illegal        - retire pulse and "not executable" flag (in WB)
//   result               - last retired result, held until the next retire
module rtype_exec_ctrl
    import rtype_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [ADDR_W-1:0] srcRegA,
    output logic [ADDR_W-1:0] srcRegB,
    input  logic [DATA_W-1:0] outBusA,
    input  logic [DATA_W-1:0] outBusB,
    output logic              regWrite,
    output logic [ADDR_W-1:0] destReg,
    output logic [DATA_W-1:0] writeData,
    output logic              done,
    output logic              illegal,
    output logic [DATA_W-1:0] result
);

    state_e              state_q, state_d;
    logic [31:0]         instr_q, instr_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;
    logic                we_q, we_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_legal;
    logic                legal;
    logic [ADDR_W-1:0]   rd;

    rtype_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opA         (opa_q),
        .opB         (opb_q),
        .shamt       (instr_q[10:6]),
        .funct       (instr_q[5:0]),
        .res         (alu_res),
        .legal_funct (alu_legal)
    );

    assign legal = (instr_q[31:26] == OP_RTYPE) && alu_legal;
    assign rd    = instr_q[15:11];

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        wdata_d   = wdata_q;
        dest_d    = dest_q;
        we_d      = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = READ;
                end
            end
            READ: begin
                opa_d   = outBusA;
                opb_d   = outBusB;
                state_d = EXEC;
            end
            EXEC: begin
                // WB-cycle outputs are prepared here so they are registered
                result_d  = legal ? alu_res : '0;
                wdata_d   = legal ? alu_res : '0;
                dest_d    = rd;
                we_d      = legal && (rd != '0);
                done_d    = 1'b1;
                illegal_d = !legal;
                state_d   = WB;
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            wdata_q   <= '0;
            dest_q    <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            wdata_q   <= wdata_d;
            dest_q    <= dest_d;
            we_q      <= we_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // Read addresses come straight from the latched word, so they are
    // stable for the whole READ cycle and hold afterwards
    assign srcRegA     = instr_q[25:21];
    assign srcRegB     = instr_q[20:16];
    assign instr_ready = reset && (state_q == IDLE);
    assign regWrite    = we_q;
    assign destReg     = dest_q;
    assign writeData   = wdata_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign result      = result_q;

endmodule

// File: tb/tb_rtype_exec_ctrl.sv
module tb_rtype_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  srcRegA, srcRegB, destReg;
    logic [31:0] outBusA, outBusB, writeData, result;
    logic        regWrite, done, illegal;

    int n_vec = 0;
    int n_err = 0;

    rtype_exec_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .srcRegA     (srcRegA),
        .srcRegB     (srcRegB),
        .outBusA     (outBusA),
        .outBusB     (outBusB),
        .regWrite    (regWrite),
        .destReg     (destReg),
        .writeData   (writeData),
        .done        (done),
        .illegal     (illegal),
        .result      (result)
    );

    always #5 clk = ~clk;

    // Register file environment: combinational reads, r0 hardwired to zero
    logic [31:0] rf [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (regWrite && destReg != 5'd0) rf[destReg] <= writeData;
    end
    assign outBusA = (srcRegA == 5'd0) ? 32'd0 : rf[srcRegA];
    assign outBusB = (srcRegB == 5'd0) ? 32'd0 : rf[srcRegB];

    // Reference state
    logic [31:0] exp_rf [32];
    logic [31:0] exp_result = '0;

    logic rst_window = 1'b0;
    int   spurious   = 0;
    always @(posedge clk) if (rst_window && (regWrite || done)) spurious++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    // Returns {legal, result} computed from the instruction semantics
    function automatic logic [32:0] ref_exec(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ok;
        int unsigned sh;
        sh = w[10:6];
        ok = 1'b1;
        r  = 32'd0;
        case (w[5:0])
            6'h20, 6'h21: r = a + b;
            6'h22, 6'h23: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B: r = (a < b) ? 32'd1 : 32'd0;
            6'h00: r = b << sh;
            6'h02: r = b >> sh;
            6'h03: r = $signed(b) >>> sh;
            default: ok = 1'b0;
        endcase
        if (w[31:26] != 6'h00) ok = 1'b0;
        if (!ok) r = 32'd0;
        return {ok, r};
    endfunction

    task automatic load_reg(input int unsigned idx, input logic [31:0] v);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = idx[4:0];
        pre_data = (idx == 0) ? 32'd0 : v;
        @(posedge clk);
        #1 pre_we = 1'b0;
        exp_rf[idx] = (idx == 0) ? 32'd0 : v;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!instr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!instr_ready) check("ready_timeout", {31'd0, instr_ready}, 32'd1);
    endtask

    // Entered just after the accepting posedge; returns at the IDLE negedge
    task automatic exec_checks(input logic [31:0] w);
        logic [32:0] r;
        logic [4:0]  rs, rt, rd;
        rs = w[25:21];
        rt = w[20:16];
        rd = w[15:11];
        @(negedge clk);
        check("read_ready", {31'd0, instr_ready}, 32'd0);
        check("read_srcA", {27'd0, srcRegA}, {27'd0, rs});
        check("read_srcB", {27'd0, srcRegB}, {27'd0, rt});
        check("read_we",   {31'd0, regWrite}, 32'd0);
        @(negedge clk);
        check("exec_ready", {31'd0, instr_ready}, 32'd0);
        check("exec_done",  {31'd0, done}, 32'd0);
        check("exec_we",    {31'd0, regWrite}, 32'd0);
        r = ref_exec(w, exp_rf[rs], exp_rf[rt]);
        exp_result = r[31:0];
        @(negedge clk);
        check("wb_ready",   {31'd0, instr_ready}, 32'd0);
        check("wb_done",    {31'd0, done}, 32'd1);
        check("wb_illegal", {31'd0, illegal}, {31'd0, !r[32]});
        check("wb_we",      {31'd0, regWrite}, {31'd0, r[32] && rd != 5'd0});
        check("wb_dest",    {27'd0, destReg}, {27'd0, rd});
        check("wb_wdata",   writeData, r[31:0]);
        check("wb_result",  result, r[31:0]);
        if (r[32] && rd != 5'd0) exp_rf[rd] = r[31:0];
        @(negedge clk);
        check("idle_ready",  {31'd0, instr_ready}, 32'd1);
        check("idle_we",     {31'd0, regWrite}, 32'd0);
        check("idle_done",   {31'd0, done}, 32'd0);
        check("idle_result", result, exp_result);
        check("rf_rd",       rf[rd], exp_rf[rd]);
    endtask

    task automatic issue(input logic [31:0] w);
        wait_ready();
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        instr = $urandom;
        exec_checks(w);
    endtask

    logic [5:0] legal_fn [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                  6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};

    initial begin
        logic [31:0] w1, w2;
        logic [5:0]  op, fn;

        reset       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        #12;
        check("rst_ready",   {31'd0, instr_ready}, 32'd0);
        check("rst_we",      {31'd0, regWrite}, 32'd0);
        check("rst_done",    {31'd0, done}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_result",  result, 32'd0);
        check("rst_wdata",   writeData, 32'd0);
        check("rst_dest",    {27'd0, destReg}, 32'd0);
        check("rst_srcA",    {27'd0, srcRegA}, 32'd0);
        check("rst_srcB",    {27'd0, srcRegB}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 check("rel_ready", {31'd0, instr_ready}, 32'd1);

        for (int unsigned i = 0; i < 32; i++) begin
            case (i)
                2:       load_reg(i, 32'd2);
                3:       load_reg(i, 32'h7FFF_FFFF);
                4:       load_reg(i, 32'd4);
                5:       load_reg(i, 32'd1);
                default: load_reg(i, $urandom);
            endcase
        end
        @(negedge clk);

        issue(32'h0044_3020);
        check("add_r6", rf[6], 32'd6);
        issue(mk(6'h00, 5'd2, 5'd4, 5'd8, 5'd0, 6'h22));
        check("sub_r8", rf[8], 32'hFFFF_FFFE);
        issue(mk(6'h00, 5'd2, 5'd8, 5'd9, 5'd0, 6'h2B));
        check("sltu_r9", rf[9], 32'd1);
        issue(mk(6'h00, 5'd2, 5'd8, 5'd10, 5'd0, 6'h2A));
        check("slt_r10", rf[10], 32'd0);
        issue(mk(6'h00, 5'd3, 5'd5, 5'd7, 5'd0, 6'h20));
        check("add_ovf_r7", rf[7], 32'h8000_0000);
        issue(mk(6'h00, 5'd0, 5'd8, 5'd11, 5'd1, 6'h03));
        check("sra_r11", rf[11], 32'hFFFF_FFFF);
        issue(mk(6'h08, 5'd2, 5'd4, 5'd15, 5'd0, 6'h20));
        check("addi_result", result, 32'd0);
        issue(mk(6'h00, 5'd2, 5'd4, 5'd16, 5'd0, 6'h3F));
        check("bad_funct_result", result, 32'd0);
        issue(mk(6'h00, 5'd2, 5'd4, 5'd0, 5'd0, 6'h20));
        check("rd0_result", result, 32'd6);
        check("rd0_r0", outBusA & 32'd0, 32'd0);

        // Back-to-back with instr_valid held high across the first instruction
        w1 = mk(6'h00, 5'd2, 5'd4, 5'd12, 5'd0, 6'h20);
        w2 = mk(6'h00, 5'd12, 5'd2, 5'd13, 5'd0, 6'h25);
        wait_ready();
        instr       = w1;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr = w2;
        exec_checks(w1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        exec_checks(w2);
        check("or_r13", rf[13], 32'd6);

        // Reset asserted during EXEC drops the instruction
        wait_ready();
        instr       = mk(6'h00, 5'd2, 5'd4, 5'd14, 5'd0, 6'h20);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_window = 1'b1;
        reset      = 1'b0;
        #1;
        check("mid_rst_ready",  {31'd0, instr_ready}, 32'd0);
        check("mid_rst_we",     {31'd0, regWrite}, 32'd0);
        check("mid_rst_done",   {31'd0, done}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_wdata",  writeData, 32'd0);
        check("mid_rst_srcA",   {27'd0, srcRegA}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        rst_window = 1'b0;
        check("mid_rst_spurious", spurious, 32'd0);
        check("mid_rst_r14", rf[14], exp_rf[14]);
        check("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        issue(mk(6'h00, 5'd2, 5'd4, 5'd17, 5'd0, 6'h20));
        check("post_rst_r17", rf[17], 32'd6);

        for (int unsigned n = 0; n < 40; n++) begin
            op = ($urandom_range(7) == 0) ? 6'($urandom_range(63)) : 6'h00;
            fn = ($urandom_range(5) == 0) ? 6'($urandom_range(63)) : legal_fn[$urandom_range(12)];
            issue(mk(op, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                     5'($urandom_range(31)), fn));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
